// File: rtl/led_pkg.sv
// Shared types and constants for the LED blink scheduler.
package led_pkg;

   // Scheduler FSM states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      OFF  = 2'd2,
      GAP  = 2'd3
   } sched_state_t;

   // Board clock frequency in Hz.
   localparam int CLK_FREQ = 100_000_000;

   // Width of a per-requester blink count.
   localparam int COUNT_W = 4;

   // Largest of three integers, used to size the shared phase timer.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return m;
   endfunction

endpackage

// File: rtl/led_blink_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from pointer+1, wrapping modulo N.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req_i,
   input  logic [N-1:0]         mask_i,
   input  logic [$clog2(N)-1:0] pointer_i,
   output logic [N-1:0]         winner_o,
   output logic                 valid_o
);

   localparam int PW = $clog2(N);

   logic [N-1:0]  eligible_s;
   logic [PW-1:0] idx_s;
   logic          found_s;
   logic          sel_s;

   assign eligible_s = req_i & ~mask_i;

   // Walk the requesters in priority order and keep only the first eligible one.
   always_comb begin
      winner_o = '0;
      found_s  = 1'b0;
      idx_s    = '0;
      sel_s    = 1'b0;
      for (int k = 1; k <= N; k++) begin
         idx_s           = PW'((int'(pointer_i) + k) % N);
         sel_s           = !found_s && eligible_s[idx_s];
         winner_o[idx_s] = winner_o[idx_s] | sel_s;
         found_s         = found_s | sel_s;
      end
      valid_o = found_s;
   end

endmodule

// File: rtl/led_blink_scheduler.sv
// Shares one status LED between N requesters, each flashing a 1..15 blink code.
module led_blink_scheduler #(
   parameter int N_REQ      = 4,
   parameter int CLK_FREQ   = led_pkg::CLK_FREQ,
   parameter int ON_CYCLES  = CLK_FREQ / 4,
   parameter int OFF_CYCLES = CLK_FREQ / 4,
   parameter int GAP_CYCLES = CLK_FREQ
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                enable,
   input  logic [N_REQ-1:0]                    req,
   input  logic [led_pkg::COUNT_W*N_REQ-1:0]   req_count,
   output logic [N_REQ-1:0]                    grant,
   output logic [N_REQ-1:0]                    ack,
   output logic                                busy,
   output logic                                led
);

   import led_pkg::*;

   localparam int TMAX = max3(ON_CYCLES, OFF_CYCLES, GAP_CYCLES);
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam int PW   = $clog2(N_REQ);

   localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
   localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);
   localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);

   sched_state_t         state_q, state_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic [COUNT_W-1:0]   remaining_q, remaining_d;
   logic [PW-1:0]        pointer_q, pointer_d;
   logic [N_REQ-1:0]     grant_q, grant_d;
   logic [N_REQ-1:0]     ack_q, ack_d;
   logic                 led_q, led_d;

   logic [N_REQ-1:0]     win_onehot_s;
   logic                 win_valid_s;
   logic [PW-1:0]        win_idx_s;
   logic [COUNT_W-1:0]   count_sel_s;
   logic                 owner_req_s;

   // The requester acked this cycle is masked so it cannot immediately re-win.
   rr_arbiter #(
      .N (N_REQ)
   ) u_arb (
      .req_i     (req),
      .mask_i    (ack_q),
      .pointer_i (pointer_q),
      .winner_o  (win_onehot_s),
      .valid_o   (win_valid_s)
   );

   // Encode the one-hot winner and pick out its blink count.
   always_comb begin
      win_idx_s   = '0;
      count_sel_s = '0;
      for (int i = 0; i < N_REQ; i++) begin
         win_idx_s   = win_idx_s | (win_onehot_s[i] ? PW'(i) : '0);
         count_sel_s = count_sel_s |
                       (win_onehot_s[i] ? req_count[i*COUNT_W +: COUNT_W] : '0);
      end
   end

   // Owner still requesting; a drop while blinking aborts the code.
   assign owner_req_s = |(req & grant_q);

   // Next-state logic for the ON/OFF/GAP sequencer.
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      remaining_d = remaining_q;
      pointer_d   = pointer_q;
      grant_d     = grant_q;
      ack_d       = '0;
      case (state_q)
         IDLE: begin
            grant_d = '0;
            if (win_valid_s) begin
               state_d     = ON;
               grant_d     = win_onehot_s;
               pointer_d   = win_idx_s;
               timer_d     = '0;
               remaining_d = (count_sel_s == 4'd0) ? 4'd1 : count_sel_s;
            end else begin
               state_d = IDLE;
            end
         end
         ON: begin
            if (!owner_req_s) begin
               state_d = GAP;
               grant_d = '0;
               timer_d = '0;
            end else if (timer_q == ON_LAST) begin
               state_d = OFF;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         OFF: begin
            if (!owner_req_s) begin
               state_d = GAP;
               grant_d = '0;
               timer_d = '0;
            end else if (timer_q == OFF_LAST) begin
               remaining_d = remaining_q - 4'd1;
               timer_d     = '0;
               state_d     = (remaining_q == 4'd1) ? GAP : ON;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         GAP: begin
            if (timer_q == GAP_LAST) begin
               state_d = IDLE;
               ack_d   = grant_q;   // zero after an abort, so no ack
               grant_d = '0;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
            timer_d = '0;
         end
      endcase
      led_d = enable && (state_d == ON);
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         timer_q     <= '0;
         remaining_q <= '0;
         pointer_q   <= PW'(N_REQ - 1);
         grant_q     <= '0;
         ack_q       <= '0;
         led_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         remaining_q <= remaining_d;
         pointer_q   <= pointer_d;
         grant_q     <= grant_d;
         ack_q       <= ack_d;
         led_q       <= led_d;
      end
   end

   assign grant = grant_q;
   assign ack   = ack_q;
   assign busy  = (state_q != IDLE);
   assign led   = led_q;

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Directed table-driven bench for led_blink_scheduler (ON=3, OFF=2, GAP=4, N=4).
module tb_led_blink_scheduler;

   logic        clk;
   logic        reset;
   logic        enable;
   logic [3:0]  req;
   logic [15:0] req_count;
   logic [3:0]  grant;
   logic [3:0]  ack;
   logic        busy;
   logic        led;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        rst_first;
      logic [3:0]  req;
      logic [15:0] cnt;
      logic        en;
      logic [3:0]  grant;
      logic [3:0]  ack;
      logic        busy;
      logic        led;
   } vec_t;

   vec_t vecs[$];

   led_blink_scheduler #(
      .N_REQ      (4),
      .CLK_FREQ   (100),
      .ON_CYCLES  (3),
      .OFF_CYCLES (2),
      .GAP_CYCLES (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .req       (req),
      .req_count (req_count),
      .grant     (grant),
      .ack       (ack),
      .busy      (busy),
      .led       (led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int row, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d got %h want %h", nm, row, act, exp);
      end
   endtask

   task automatic add(input logic rf, input logic [3:0] rq, input logic [15:0] cn, input logic en,
                      input logic [3:0] gr, input logic [3:0] ak, input logic bz, input logic ld);
      vec_t v;
      v.rst_first = rf; v.req = rq; v.cnt = cn; v.en = en;
      v.grant = gr; v.ack = ak; v.busy = bz; v.led = ld;
      vecs.push_back(v);
   endtask

   // Reset asserted mid-cycle; outputs must clear at once and stay clear after release.
   task automatic do_reset(input int row);
      @(posedge clk);
      #3;
      reset = 1'b1;
      req   = 4'b0000;
      #1;
      chk("rst_grant", row, grant, 4'b0000);
      chk("rst_ack",   row, ack,   4'b0000);
      chk("rst_busy",  row, {3'b000, busy}, 4'b0000);
      chk("rst_led",   row, {3'b000, led},  4'b0000);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("rel_grant", row, grant, 4'b0000);
      chk("rel_busy",  row, {3'b000, busy}, 4'b0000);
      chk("rel_led",   row, {3'b000, led},  4'b0000);
      @(negedge clk);
   endtask

   initial begin
      reset     = 1'b1;
      enable    = 1'b1;
      req       = 4'b0000;
      req_count = 16'h0000;

      // Single request, count 2 (changed to 15 after grant), held one cycle into the ack cycle.
      for (int c = 1; c <= 17; c++)
         add(c == 1, (c <= 16) ? 4'b0010 : 4'b0000, (c == 1) ? 16'h0020 : 16'h00F0, 1'b1,
             (c <= 14) ? 4'b0010 : 4'b0000, (c == 15) ? 4'b0010 : 4'b0000,
             c <= 14, (c >= 1 && c <= 3) || (c >= 6 && c <= 8));

      // Count 0 on req[3] clamps to a single blink.
      for (int c = 1; c <= 11; c++)
         add(c == 1, (c <= 10) ? 4'b1000 : 4'b0000, 16'h0000, 1'b1,
             (c <= 9) ? 4'b1000 : 4'b0000, (c == 10) ? 4'b1000 : 4'b0000,
             c <= 9, c <= 3);

      // Abort: req[1] dropped during the second ON cycle.
      for (int c = 1; c <= 8; c++)
         add(c == 1, (c <= 2) ? 4'b0010 : 4'b0000, 16'h0020, 1'b1,
             (c <= 2) ? 4'b0010 : 4'b0000, 4'b0000, c <= 6, c <= 2);

      // Contention between req[0] and req[2], then req[0] re-asserted.
      for (int c = 1; c <= 21; c++)
         add(c == 1,
             (c <= 10) ? 4'b0101 : (c == 11) ? 4'b0100 : (c <= 20) ? 4'b0101 : 4'b0001,
             16'h0101, 1'b1,
             (c <= 9) ? 4'b0001 : (c == 10) ? 4'b0000 : (c <= 19) ? 4'b0100 :
                 (c == 20) ? 4'b0000 : 4'b0001,
             (c == 10) ? 4'b0001 : (c == 20) ? 4'b0100 : 4'b0000,
             !(c == 10 || c == 20),
             (c <= 3) || (c >= 11 && c <= 13) || (c == 21));

      // enable=0: same timing as the single request, LED never lit.
      for (int c = 1; c <= 17; c++)
         add(c == 1, (c <= 16) ? 4'b0010 : 4'b0000, 16'h0020, 1'b0,
             (c <= 14) ? 4'b0010 : 4'b0000, (c == 15) ? 4'b0010 : 4'b0000,
             c <= 14, 1'b0);

      for (int r = 0; r < vecs.size(); r++) begin
         if (vecs[r].rst_first) do_reset(r);
         req       = vecs[r].req;
         req_count = vecs[r].cnt;
         enable    = vecs[r].en;
         @(posedge clk);
         #1;
         chk("grant", r, grant, vecs[r].grant);
         chk("ack",   r, ack,   vecs[r].ack);
         chk("busy",  r, {3'b000, busy}, {3'b000, vecs[r].busy});
         chk("led",   r, {3'b000, led},  {3'b000, vecs[r].led});
         @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_blink_scheduler.md
Name: led_blink_scheduler

Overview:
- Shares one status LED between N requesters. Each requester asks to flash a pulse code of 1..15 blinks on the LED.
- Round-robin arbitration picks one requester at a time. The block then runs an ON/OFF/GAP timing state machine and acks the requester when its code is done.
- Sits between firmware-visible status sources and the board LED pin.
- Keeps the codebase's output-gating idiom: an enable input forces the LED low without disturbing sequencing.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- CLK_FREQ, 100_000_000, clock frequency in Hz (shared constant)
- ON_CYCLES, CLK_FREQ/4, LED-high cycles per blink (>=1)
- OFF_CYCLES, CLK_FREQ/4, LED-low cycles between blinks (>=1)
- GAP_CYCLES, CLK_FREQ, LED-low separation after a code (>=1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  1 = drive LED; 0 = LED forced 0, sequencing continues
- req  in  N_REQ  request per requester; held high until ack
- req_count  in  4*N_REQ  blink count for requester i at bits [4i+3:4i]
- grant  out  N_REQ  one-hot current owner
- ack  out  N_REQ  one-cycle pulse when owner's code completed
- busy  out  1  state != IDLE
- led  out  1  LED drive

Behaviour:
- Reset (async, any state) forces:
  - state=IDLE; grant=0, ack=0, busy=0, led=0
  - timer=0, remaining=0
  - rr pointer=N_REQ-1, so req[0] has first priority
- All outputs are registered or decoded from registered state only. No combinational path from req to any output.
- States: IDLE, ON, OFF, GAP.
- IDLE:
  - If any eligible req, the round-robin winner is searched from pointer+1 upward modulo N_REQ.
  - Next cycle: state=ON, grant=onehot(winner), pointer=winner, timer=0.
  - remaining = req_count[winner], latched at grant. A count of 0 is clamped to 1.
  - Latency: req sampled high at edge t gives grant and led high from cycle t+1.
- ON: led=enable. When timer==ON_CYCLES-1, go to OFF with timer=0; otherwise timer++.
- OFF: led=0. When timer==OFF_CYCLES-1, remaining--; go to GAP if remaining was 1, else ON. timer=0 on either transition.
- GAP: led=0, grant held. When timer==GAP_CYCLES-1, go to IDLE; grant cleared and ack[owner]=1 for exactly that first IDLE cycle.
- Ack cycle:
  - The acked requester is masked from arbitration in the ack cycle itself; it must drop req after ack.
  - Other requesters may win in the ack cycle, giving ON on the next cycle (back-to-back codes).
  - If only the acked requester is still requesting, it is eligible again from the following cycle.
- Abort:
  - Owner's req low while in ON or OFF: next cycle state=GAP, grant=0, led=0, timer=0.
  - GAP completes normally; no ack is generated on abort.
  - req changes during GAP are ignored.
- req_count changes after grant have no effect on the running code.
- Total code time from grant: n*(ON_CYCLES+OFF_CYCLES)+GAP_CYCLES cycles.
- Timer width is $clog2(max(ON_CYCLES,OFF_CYCLES,GAP_CYCLES)).
- remaining is 4 bits and never wraps, because of the clamp.
- enable only gates led; the grant/ack timing is identical with enable=0.

Decomposition:
- Package led_pkg:
  - state enum typedef sched_state_t {IDLE, ON, OFF, GAP}
  - CLK_FREQ constant
  - COUNT_W=4 constant
- Sub-module rr_arbiter (N parameter): inputs req, mask, pointer; output one-hot winner plus valid. Purely combinational.
- The scheduler instantiates rr_arbiter once and holds the FSM, timer, remaining and pointer registers.

Test Plan (ON_CYCLES=3, OFF_CYCLES=2, GAP_CYCLES=4, N_REQ=4):
- Reset asserted mid-cycle, then released with req=0 -> grant=0, ack=0, busy=0, led=0 immediately and held.
- Single request: req[1]=1, count=2 at edge 0:
  - grant=4'b0010 from cycle 1
  - led high cycles 1-3 and 6-8
  - ack[1] pulse at cycle 15, busy=0 at cycle 15
- Contention: req[0] and req[2] both requested at edge 0 (count=1) after reset:
  - req[0] granted first, ack[0] at cycle 10
  - grant=4'b0100 at cycle 11; req[0] re-asserted is not served before req[2]
- Count 0 clamp: req[3] with count=0 -> exactly one blink, ack at cycle 10.
- Abort: req[1] dropped during cycle 2 of ON:
  - led=0 and grant=0 from cycle 3
  - no ack; busy low after 4 GAP cycles
- enable=0 with single request count=2 -> led stays 0 throughout; grant/ack timing identical to the single-request scenario.
